sliding_mean_filter: RTL and testbench

SLIDING_MEAN_FILTER -- requirements
Module: sliding_mean_filter

---
 rtl/sliding_mean_pkg.sv | 25 ++
 rtl/sliding_mean_filter_delay_line.sv | 40 ++++
 rtl/sliding_mean_filter.sv | 163 ++++++++++++++++
 tb/tb_sliding_mean_filter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sliding_mean_pkg.sv
// Shared helpers for the sliding mean filter: window/shift/sum-width derivation
// and the parameter legality predicate used at elaboration.
package sliding_mean_pkg;

    function automatic int win_f(input int radius);
        return 32'sd2 * radius;
    endfunction

    function automatic int shift_f(input int radius);
        return $clog2(32'sd2 * radius);
    endfunction

    function automatic int sum_w_f(input int pixel_w, input int radius);
        return pixel_w + $clog2(32'sd2 * radius);
    endfunction

    // Window must be a non-zero power of two and strictly narrower than a line.
    function automatic bit params_ok(input int pixel_w, input int radius, input int frame_width);
        int win;
        win = 32'sd2 * radius;
        return (pixel_w > 32'sd0) && (radius > 32'sd0) &&
               ((win & (win - 32'sd1)) == 32'sd0) && (frame_width > win);
    endfunction

endpackage

// File: rtl/sliding_mean_filter_delay_line.sv
// Enable-gated shift register; dout is the sample written DEPTH enables ago.
module pixel_delay_line #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [DEPTH-1:0][WIDTH-1:0] taps_q;
    logic [DEPTH-1:0][WIDTH-1:0] taps_d;

    // Next-state of the tap chain
    always_comb begin
        taps_d = taps_q;
        if (en) begin
            taps_d[0] = din;
            for (int i = 1; i < DEPTH; i++) begin
                taps_d[i] = taps_q[i-1];
            end
        end else begin
            taps_d = taps_q;
        end
    end

    // Tap chain register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            taps_q <= '0;
        end else begin
            taps_q <= taps_d;
        end
    end

    assign dout = taps_q[DEPTH-1];

endmodule

// File: rtl/sliding_mean_filter.sv
// Per-line sliding window mean/contrast filter, two-stage pipeline.
// Optional macro SLIDING_MEAN_ROUND_EN selects round-to-nearest averaging.
module sliding_mean_filter
    import sliding_mean_pkg::*;
#(
    parameter int PIXEL_W     = 8,
    parameter int RADIUS      = 8,
    parameter int FRAME_WIDTH = 128
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [PIXEL_W:0]   pixel,
    input  logic               pixel_valid,
    output logic [PIXEL_W:0]   out_pixel,
    output logic [PIXEL_W-1:0] local_average,
    output logic [PIXEL_W:0]   local_contrast,
    output logic               out_valid
);

    localparam int WIN   = win_f(RADIUS);
    localparam int SHIFT = shift_f(RADIUS);
    localparam int SUM_W = sum_w_f(PIXEL_W, RADIUS);
    localparam int COL_W = $clog2(FRAME_WIDTH);

    if (!params_ok(PIXEL_W, RADIUS, FRAME_WIDTH)) begin : g_bad_params
        $error("sliding_mean_filter: WIN=2*RADIUS must be a power of two below FRAME_WIDTH");
    end

    logic               sof_s;
    logic [PIXEL_W-1:0] val_s;
    logic [PIXEL_W-1:0] win_tap_s;
    logic [PIXEL_W-1:0] mid_tap_s;

    assign sof_s = pixel[PIXEL_W];
    assign val_s = pixel[PIXEL_W-1:0];

    pixel_delay_line #(.WIDTH(PIXEL_W), .DEPTH(WIN)) u_win_delay (
        .clk   (clk),
        .reset (reset),
        .en    (pixel_valid),
        .din   (val_s),
        .dout  (win_tap_s)
    );

    pixel_delay_line #(.WIDTH(PIXEL_W), .DEPTH(RADIUS)) u_mid_delay (
        .clk   (clk),
        .reset (reset),
        .en    (pixel_valid),
        .din   (val_s),
        .dout  (mid_tap_s)
    );

    logic               started_q, started_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [SUM_W-1:0]   sum_q, sum_d;
    logic [PIXEL_W-1:0] centre_q, centre_d;
    logic               s1_valid_q, s1_valid_d;
    logic               s1_sol_q, s1_sol_d;

    // Stage 1: column tracking, running window sum, centre tap
    always_comb begin
        started_d  = started_q;
        col_d      = col_q;
        sum_d      = sum_q;
        centre_d   = centre_q;
        s1_valid_d = 1'b0;
        s1_sol_d   = 1'b0;
        if (pixel_valid) begin
            // A new line starts on sof, on line wrap, or on the first sample after reset.
            if (sof_s || !started_q || (col_q == COL_W'(FRAME_WIDTH - 1))) begin
                col_d = '0;
            end else begin
                col_d = col_q + COL_W'(1);
            end
            started_d = 1'b1;
            if (col_d == '0) begin
                sum_d = SUM_W'(val_s);
            end else if (col_d < COL_W'(WIN)) begin
                sum_d = sum_q + SUM_W'(val_s);
            end else begin
                sum_d = sum_q + SUM_W'(val_s) - SUM_W'(win_tap_s);
            end
            centre_d   = mid_tap_s;
            s1_valid_d = (col_d >= COL_W'(WIN - 1));
            s1_sol_d   = (col_d == COL_W'(WIN - 1));
        end else begin
            s1_valid_d = 1'b0;
        end
    end

    // Stage 1 registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            started_q  <= 1'b0;
            col_q      <= '0;
            sum_q      <= '0;
            centre_q   <= '0;
            s1_valid_q <= 1'b0;
            s1_sol_q   <= 1'b0;
        end else begin
            started_q  <= started_d;
            col_q      <= col_d;
            sum_q      <= sum_d;
            centre_q   <= centre_d;
            s1_valid_q <= s1_valid_d;
            s1_sol_q   <= s1_sol_d;
        end
    end

    logic [PIXEL_W-1:0] avg_s;
    logic [PIXEL_W:0]   con_s;
`ifdef SLIDING_MEAN_ROUND_EN
    logic [SUM_W:0]     rounded_s;
`endif

    logic [PIXEL_W:0]   out_pixel_q, out_pixel_d;
    logic [PIXEL_W-1:0] avg_q, avg_d;
    logic [PIXEL_W:0]   con_q, con_d;
    logic               out_valid_q, out_valid_d;

    // Stage 2: mean, contrast and output hold
    always_comb begin
`ifdef SLIDING_MEAN_ROUND_EN
        rounded_s = {1'b0, sum_q} + (SUM_W + 1)'(WIN / 2);
        avg_s     = PIXEL_W'(rounded_s >> SHIFT);
`else
        avg_s     = PIXEL_W'(sum_q >> SHIFT);
`endif
        con_s       = {1'b0, centre_q} - {1'b0, avg_s};
        out_valid_d = s1_valid_q;
        out_pixel_d = out_pixel_q;
        avg_d       = avg_q;
        con_d       = con_q;
        if (s1_valid_q) begin
            out_pixel_d = {s1_sol_q, centre_q};
            avg_d       = avg_s;
            con_d       = con_s;
        end else begin
            out_pixel_d = out_pixel_q;
        end
    end

    // Stage 2 registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_pixel_q <= '0;
            avg_q       <= '0;
            con_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_pixel_q <= out_pixel_d;
            avg_q       <= avg_d;
            con_q       <= con_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_pixel      = out_pixel_q;
    assign local_average  = avg_q;
    assign local_contrast = con_q;
    assign out_valid      = out_valid_q;

endmodule

// File: tb/tb_sliding_mean_filter.sv
// Self-checking bench: directed vector table, hand-written corner sequences and
// randomized traffic against a line-buffer reference model.
module tb_sliding_mean_filter;

    localparam int PW  = 8;
    localparam int R   = 2;
    localparam int WIN = 4;
    localparam int FW  = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [PW:0]   pixel;
    logic          pixel_valid;
    logic [PW:0]   out_pixel;
    logic [PW-1:0] local_average;
    logic [PW:0]   local_contrast;
    logic          out_valid;

    sliding_mean_filter #(.PIXEL_W(PW), .RADIUS(R), .FRAME_WIDTH(FW)) dut (
        .clk            (clk),
        .reset          (reset),
        .pixel          (pixel),
        .pixel_valid    (pixel_valid),
        .out_pixel      (out_pixel),
        .local_average  (local_average),
        .local_contrast (local_contrast),
        .out_valid      (out_valid)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    typedef struct {
        int          due;
        logic [PW:0] pix;
        logic [7:0]  avg;
        logic [PW:0] con;
    } exp_t;

    exp_t        expq[$];
    int          line_q[$];
    bit          started = 1'b0;
    logic [PW:0] last_pix = '0;
    logic [7:0]  last_avg = '0;
    logic [PW:0] last_con = '0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: each line is a list of pixels; output = mean of last WIN, centre = col-R.
    task automatic model_sample(input bit sof, input int val);
        int   col, sum, avg, centre;
        exp_t e;
        if (!started || sof || line_q.size() == FW) line_q.delete();
        started = 1'b1;
        line_q.push_back(val);
        col = line_q.size() - 1;
        if (col >= WIN - 1) begin
            sum = 0;
            for (int k = col - WIN + 1; k <= col; k++) sum += line_q[k];
`ifdef SLIDING_MEAN_ROUND_EN
            avg = (sum + WIN / 2) / WIN;
`else
            avg = sum / WIN;
`endif
            centre = line_q[col - R];
            e.due  = cyc + 1;
            e.pix  = {(col == WIN - 1), 8'(centre)};
            e.avg  = 8'(avg);
            e.con  = 9'(centre - avg);
            expq.push_back(e);
        end
    endtask

    task automatic check_outputs();
        exp_t e;
        if (expq.size() > 0 && expq[0].due == cyc) begin
            e = expq.pop_front();
            cmp("out_valid", out_valid, 1);
            cmp("out_pixel", out_pixel, e.pix);
            cmp("local_average", local_average, e.avg);
            cmp("local_contrast", local_contrast, e.con);
            last_pix = e.pix;
            last_avg = e.avg;
            last_con = e.con;
        end else begin
            cmp("out_valid_idle", out_valid, 0);
            cmp("hold_out_pixel", out_pixel, last_pix);
            cmp("hold_local_average", local_average, last_avg);
            cmp("hold_local_contrast", local_contrast, last_con);
        end
    endtask

    task automatic cycle(input bit v, input bit sof, input int val);
        pixel       = {sof, 8'(val)};
        pixel_valid = v;
        @(posedge clk);
        cyc++;
        if (v) model_sample(sof, val);
        @(negedge clk);
        check_outputs();
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        #1;
        cmp("rst_out_valid", out_valid, 0);
        cmp("rst_out_pixel", out_pixel, 0);
        cmp("rst_local_average", local_average, 0);
        cmp("rst_local_contrast", local_contrast, 0);
        expq.delete();
        line_q.delete();
        started  = 1'b0;
        last_pix = '0;
        last_avg = '0;
        last_con = '0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    typedef struct {
        bit          v;
        bit          sof;
        int          val;
        bit          ev;
        logic [PW:0] pix;
        logic [7:0]  avg;
        logic [PW:0] con;
    } vec_t;

    vec_t tbl[10];
    int   strobe_avg[$];
    int   strobe_cyc[$];
    int   rnd_v, rnd_sof, rnd_val;

    initial begin
        // Ramp 0,4,..,28: outputs for columns 3..7 appear one vector after their sample.
        for (int i = 0; i < 10; i++) begin
            tbl[i].v   = (i < 8);
            tbl[i].sof = (i == 0);
            tbl[i].val = (i < 8) ? 4 * i : 0;
            tbl[i].ev  = 1'b0;
            tbl[i].pix = '0;
            tbl[i].avg = '0;
            tbl[i].con = '0;
        end
        tbl[4].ev = 1'b1; tbl[4].pix = 9'h104; tbl[4].avg = 8'd6;  tbl[4].con = 9'h1FE;
        tbl[5].ev = 1'b1; tbl[5].pix = 9'h008; tbl[5].avg = 8'd10; tbl[5].con = 9'h1FE;
        tbl[6].ev = 1'b1; tbl[6].pix = 9'h00C; tbl[6].avg = 8'd14; tbl[6].con = 9'h1FE;
        tbl[7].ev = 1'b1; tbl[7].pix = 9'h010; tbl[7].avg = 8'd18; tbl[7].con = 9'h1FE;
        tbl[8].ev = 1'b1; tbl[8].pix = 9'h014; tbl[8].avg = 8'd22; tbl[8].con = 9'h1FE;

        reset       = 1'b1;
        pixel       = '0;
        pixel_valid = 1'b0;
        repeat (2) @(negedge clk);
        cmp("reset_out_valid", out_valid, 0);
        cmp("reset_out_pixel", out_pixel, 0);
        cmp("reset_local_average", local_average, 0);
        cmp("reset_local_contrast", local_contrast, 0);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            cycle(tbl[i].v, tbl[i].sof, tbl[i].val);
            cmp("tbl_out_valid", out_valid, tbl[i].ev);
            if (tbl[i].ev) begin
                cmp("tbl_out_pixel", out_pixel, tbl[i].pix);
                cmp("tbl_local_average", local_average, tbl[i].avg);
                cmp("tbl_local_contrast", local_contrast, tbl[i].con);
            end
        end

        // Constant 255 line.
        for (int i = 0; i < 10; i++) begin
            cycle(i < 8, i == 0, 255);
            if (i >= 4 && i <= 8) begin
                cmp("const_valid", out_valid, 1);
                cmp("const_average", local_average, 255);
                cmp("const_contrast", local_contrast, 0);
            end
        end

        // 1,2,2,2: sum 7 -> truncates to 1, rounds to 2.
        cycle(1, 1, 1);
        cycle(1, 0, 2);
        cycle(1, 0, 2);
        cycle(1, 0, 2);
        cycle(0, 0, 0);
        cmp("round_valid", out_valid, 1);
`ifdef SLIDING_MEAN_ROUND_EN
        cmp("round_average", local_average, 2);
        cmp("round_contrast", local_contrast, 0);
`else
        cmp("round_average", local_average, 1);
        cmp("round_contrast", local_contrast, 1);
`endif
        cycle(0, 0, 0);

        // sof at column 5: new columns 0..2 produce nothing; new average excludes old line.
        for (int i = 0; i < 5; i++) cycle(1, i == 0, 50 + 10 * i);
        cycle(1, 1, 100);
        cycle(1, 0, 110);
        cmp("midsof_quiet_c0", out_valid, 0);
        cycle(1, 0, 120);
        cmp("midsof_quiet_c1", out_valid, 0);
        cycle(1, 0, 130);
        cmp("midsof_quiet_c2", out_valid, 0);
        cycle(0, 0, 0);
        cmp("midsof_valid", out_valid, 1);
        cmp("midsof_average", local_average, 115);
        cmp("midsof_pixel", out_pixel, 9'h16E);
        cmp("midsof_contrast", local_contrast, 9'h1FB);
        cycle(0, 0, 0);

        // Ramp with pixel_valid toggling; idle slots carry a stray sof bit.
        for (int i = 0; i < 8; i++) begin
            cycle(1, i == 0, 4 * i);
            if (out_valid) begin strobe_avg.push_back(local_average); strobe_cyc.push_back(cyc); end
            cycle(0, 1, 99);
            if (out_valid) begin strobe_avg.push_back(local_average); strobe_cyc.push_back(cyc); end
        end
        cmp("toggle_strobes", strobe_avg.size(), 5);
        for (int i = 0; i < strobe_avg.size() && i < 5; i++) begin
            cmp("toggle_average", strobe_avg[i], 6 + 4 * i);
            if (i > 0) cmp("toggle_spacing", strobe_cyc[i] - strobe_cyc[i-1], 2);
        end
        cycle(0, 0, 0);

        // Reset at column 6, then first pixel (no sof) counts as column 0.
        for (int i = 0; i < 7; i++) cycle(1, i == 0, 200 - 10 * i);
        do_reset();
        cycle(1, 0, 10);
        cycle(1, 0, 20);
        cycle(1, 0, 30);
        cycle(1, 0, 40);
        cycle(0, 0, 0);
        cmp("postrst_valid", out_valid, 1);
        cmp("postrst_average", local_average, 25);
        cmp("postrst_pixel", out_pixel, 9'h114);
        cmp("postrst_contrast", local_contrast, 9'h1FB);
        cycle(0, 0, 0);

        // Random traffic with one mid-stream reset.
        for (int i = 0; i < 600; i++) begin
            rnd_v   = ($urandom_range(0, 3) != 0);
            rnd_sof = ($urandom_range(0, 15) == 0);
            rnd_val = $urandom_range(0, 255);
            cycle(rnd_v[0], rnd_sof[0], rnd_val);
            if (i == 300) do_reset();
        end
        repeat (3) cycle(0, 0, 0);
        cmp("expected_drained", expq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
